// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (instruction fetch / data access) memory arbiter.
// One transaction outstanding at a time, sequenced IDLE -> ISSUE -> WAIT -> DONE.
// A request seen in IDLE at cycle t completes with a done pulse at t+LATENCY+2.
// Optional build macro ARB_RR_EN: round-robin arbitration on contention
// (the side that lost the previous contention wins; D wins first after reset).
// Without it, a data request always beats a fetch request.
module mem_arbiter #(
    parameter int LATENCY = 4,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [DW-1:0] i_addr,
    output logic          i_done,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_wr,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // WAIT holds for LATENCY cycles, counting LATENCY-1 down to zero.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic          r_owner_d;
    logic          r_wr;
    logic          r_mem_en;
    logic          r_mem_wr;
    logic [DW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_i_done;
    logic          r_d_done;
    logic [DW-1:0] r_i_rdata;
    logic [DW-1:0] r_d_rdata;
    logic          r_busy;
    logic          w_grant_d;

`ifdef ARB_RR_EN
    logic r_last_d;

    // Contention goes to the side that lost the previous contention; lone requests win outright.
    always_comb begin
        w_grant_d = 1'b0;
        if (d_req && i_req) begin
            w_grant_d = !r_last_d;
        end else if (d_req) begin
            w_grant_d = 1'b1;
        end else begin
            w_grant_d = 1'b0;
        end
    end

    // Remember who won the most recent contended arbitration (reset value makes D win first).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if ((r_state == ST_IDLE) && d_req && i_req) begin
            r_last_d <= w_grant_d;
        end else begin
            r_last_d <= r_last_d;
        end
    end
`else
    // Fixed priority: a data request always beats a fetch request.
    always_comb begin
        w_grant_d = 1'b0;
        if (d_req) begin
            w_grant_d = 1'b1;
        end else begin
            w_grant_d = 1'b0;
        end
    end
`endif

    // Transaction sequencer with registered memory-side and requester-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_owner_d   <= 1'b0;
            r_wr        <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= {DW{1'b0}};
            r_mem_wdata <= {DW{1'b0}};
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_i_rdata   <= {DW{1'b0}};
            r_d_rdata   <= {DW{1'b0}};
            r_busy      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            r_mem_en <= 1'b0;
            r_mem_wr <= 1'b0;
            r_i_done <= 1'b0;
            r_d_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        // Latch the winner's request; later input changes are ignored.
                        r_owner_d  <= w_grant_d;
                        r_wr       <= w_grant_d & d_wr;
                        r_mem_en   <= 1'b1;
                        r_mem_wr   <= w_grant_d & d_wr;
                        r_mem_addr <= w_grant_d ? d_addr : i_addr;
                        if (w_grant_d) begin
                            r_mem_wdata <= d_wdata;
                        end else begin
                            r_mem_wdata <= r_mem_wdata;
                        end
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= CNT_LOAD;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // Memory data is valid this cycle; writes leave d_rdata untouched.
                        if (r_owner_d) begin
                            r_d_done <= 1'b1;
                            if (!r_wr) begin
                                r_d_rdata <= mem_rdata;
                            end else begin
                                r_d_rdata <= r_d_rdata;
                            end
                        end else begin
                            r_i_done  <= 1'b1;
                            r_i_rdata <= mem_rdata;
                        end
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_done    = r_i_done;
    assign i_rdata   = r_i_rdata;
    assign d_done    = r_d_done;
    assign d_rdata   = r_d_rdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed steps followed by randomized traffic,
// all checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LAT = 4;
    localparam int DW  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_wr;
    logic [DW-1:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic          i_done, d_done, mem_en, mem_wr, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    logic          l1_i_req, l1_d_req, l1_d_wr;
    logic [DW-1:0] l1_i_addr, l1_d_addr, l1_d_wdata, l1_mem_rdata;
    logic          l1_i_done, l1_d_done, l1_mem_en, l1_mem_wr, l1_busy;
    logic [DW-1:0] l1_i_rdata, l1_d_rdata, l1_mem_addr, l1_mem_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.LATENCY(1), .DW(DW)) dut_l1 (
        .clk(clk), .rst(rst),
        .i_req(l1_i_req), .i_addr(l1_i_addr), .i_done(l1_i_done), .i_rdata(l1_i_rdata),
        .d_req(l1_d_req), .d_wr(l1_d_wr), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
        .d_done(l1_d_done), .d_rdata(l1_d_rdata),
        .mem_en(l1_mem_en), .mem_wr(l1_mem_wr), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata), .busy(l1_busy)
    );

    int  cyc = 0;
    int  n_vec = 0;
    int  n_err = 0;
    bit  check_en = 1'b0;
    bit  rnd_mode = 1'b0;

    // requester agents: outstanding request counts and the values they present
    int            i_cnt = 0;
    int            d_cnt = 0;
    logic [DW-1:0] a_i_addr = '0, a_d_addr = '0, a_d_wdata = '0;
    logic          a_d_wr = 1'b0;

    // reference model: the one transaction in flight, granted in cycle g_cyc
    bit            have_tx = 1'b0;
    bit            tx_d = 1'b0;
    bit            tx_wr = 1'b0;
    int            g_cyc = 0;
    logic [DW-1:0] tx_addr = '0, tx_wdata = '0, tx_rdata = '0;
    bit            last_d = 1'b0;
    logic [DW-1:0] e_i_rdata = '0, e_d_rdata = '0, e_mem_addr = '0, e_mem_wdata = '0;
    logic [DW-1:0] mem_m [logic [DW-1:0]];

    // observations for the directed steps
    int  obs_i_done_cyc = -1;
    int  obs_d_done_cyc = -1;
    int  n_d_done = 0;
    int  idone_q[$];
    bit  prev_mem_en = 1'b0;
    bit  consec_seen = 1'b0;
    int  t = 0;

    function automatic logic [DW-1:0] mem_rd(input logic [DW-1:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        else return a ^ 16'hA5A5;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs at the falling edge, then drive this cycle's inputs.
    task automatic tick(input bit rst_now);
        logic e_mem_en, e_mem_wr, e_i_done, e_d_done, e_busy;
        bit   gd;
        @(negedge clk);
        cyc++;
        e_mem_en = 1'b0; e_mem_wr = 1'b0; e_i_done = 1'b0; e_d_done = 1'b0; e_busy = 1'b0;
        if (have_tx) begin
            e_busy = (cyc > g_cyc);
            if (cyc == g_cyc + 1) begin
                e_mem_en    = 1'b1;
                e_mem_wr    = tx_wr;
                e_mem_addr  = tx_addr;
                e_mem_wdata = tx_wdata;
                if (tx_wr) mem_m[tx_addr] = tx_wdata;
            end
            if (cyc == g_cyc + LAT + 2) begin
                if (tx_d) begin
                    e_d_done = 1'b1;
                    if (!tx_wr) e_d_rdata = tx_rdata;
                    d_cnt--;
                end else begin
                    e_i_done  = 1'b1;
                    e_i_rdata = tx_rdata;
                    i_cnt--;
                end
            end
        end
        if (check_en) begin
            chk1("busy", busy, e_busy);
            chk1("mem_en", mem_en, e_mem_en);
            chk1("mem_wr", mem_wr, e_mem_wr);
            chk1("i_done", i_done, e_i_done);
            chk1("d_done", d_done, e_d_done);
            chk16("mem_addr", mem_addr, e_mem_addr);
            chk16("mem_wdata", mem_wdata, e_mem_wdata);
            chk16("i_rdata", i_rdata, e_i_rdata);
            chk16("d_rdata", d_rdata, e_d_rdata);
        end
        if (i_done === 1'b1) begin obs_i_done_cyc = cyc; idone_q.push_back(cyc); end
        if (d_done === 1'b1) begin obs_d_done_cyc = cyc; n_d_done++; end
        if ((mem_en === 1'b1) && prev_mem_en) consec_seen = 1'b1;
        prev_mem_en = (mem_en === 1'b1);

        if (rst_now) begin
            rst = 1'b1;
            i_cnt = 0; d_cnt = 0; have_tx = 1'b0; last_d = 1'b0;
            e_i_rdata = '0; e_d_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0;
        end else begin
            rst = 1'b0;
            // owner may change its inputs after the grant; the arbiter must ignore them
            if (rnd_mode && have_tx && (cyc > g_cyc)) begin
                if (tx_d) begin
                    a_d_addr = 16'($urandom); a_d_wdata = 16'($urandom); a_d_wr = 1'($urandom);
                end else begin
                    a_i_addr = 16'($urandom);
                end
            end
            if (rnd_mode && (i_cnt == 0) && ($urandom_range(0, 3) == 0)) begin
                i_cnt = 1; a_i_addr = {12'h000, 4'($urandom)};
            end
            if (rnd_mode && (d_cnt == 0) && ($urandom_range(0, 3) == 0)) begin
                d_cnt = 1; a_d_addr = {12'h000, 4'($urandom)};
                a_d_wdata = 16'($urandom); a_d_wr = 1'($urandom);
            end
            if (!have_tx && ((i_cnt > 0) || (d_cnt > 0))) begin
                if ((i_cnt > 0) && (d_cnt > 0)) begin
`ifdef ARB_RR_EN
                    gd = !last_d;
                    last_d = gd;
`else
                    gd = 1'b1;
`endif
                end else begin
                    gd = (d_cnt > 0);
                end
                have_tx = 1'b1; g_cyc = cyc; tx_d = gd;
                if (gd) begin
                    tx_wr = a_d_wr; tx_addr = a_d_addr; tx_wdata = a_d_wdata;
                end else begin
                    tx_wr = 1'b0; tx_addr = a_i_addr; tx_wdata = e_mem_wdata;
                end
                tx_rdata = mem_rd(tx_addr);
            end
        end
        i_req   = (i_cnt > 0);
        d_req   = (d_cnt > 0);
        i_addr  = a_i_addr;
        d_addr  = a_d_addr;
        d_wdata = a_d_wdata;
        d_wr    = a_d_wr;
        // correct data only in the capture cycle, noise otherwise
        if (have_tx && !tx_wr && (cyc == g_cyc + 1 + LAT)) mem_rdata = tx_rdata;
        else mem_rdata = 16'($urandom);
        if (have_tx && (cyc == g_cyc + LAT + 2)) have_tx = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        l1_i_req = 1'b0; l1_d_req = 1'b0; l1_d_wr = 1'b0;
        l1_i_addr = '0; l1_d_addr = '0; l1_d_wdata = '0; l1_mem_rdata = '0;
        tick(1'b1);
        tick(1'b1);
        check_en = 1'b1;
        tick(1'b0);

        // LATENCY=1 build: issue t+1, capture t+2, done t+3
        l1_i_addr = 16'h0040; l1_i_req = 1'b1;
        tick(1'b0);
        chk1("l1_mem_en", l1_mem_en, 1'b1);
        chk16("l1_mem_addr", l1_mem_addr, 16'h0040);
        chk1("l1_mem_wr", l1_mem_wr, 1'b0);
        l1_mem_rdata = 16'h1111;
        tick(1'b0);
        chk1("l1_busy_wait", l1_busy, 1'b1);
        chk1("l1_done_early", l1_i_done, 1'b0);
        l1_mem_rdata = 16'hC0DE;
        tick(1'b0);
        chk1("l1_done", l1_i_done, 1'b1);
        chk16("l1_rdata", l1_i_rdata, 16'hC0DE);
        l1_i_req = 1'b0; l1_mem_rdata = 16'h0000;
        tick(1'b0);
        chk1("l1_busy_end", l1_busy, 1'b0);
        chk1("l1_done_end", l1_i_done, 1'b0);

        // lone fetch of 0x0010 returning 0xBEEF
        mem_m[16'h0010] = 16'hBEEF;
        a_i_addr = 16'h0010; i_cnt = 1; obs_i_done_cyc = -1;
        tick(1'b0); t = cyc;
        repeat (8) tick(1'b0);
        chki("fetch_latency", obs_i_done_cyc - t, 6);
        chk16("fetch_rdata", i_rdata, 16'hBEEF);

        // data write 0x1234 -> 0x0200
        a_d_addr = 16'h0200; a_d_wdata = 16'h1234; a_d_wr = 1'b1; d_cnt = 1; obs_d_done_cyc = -1;
        tick(1'b0); t = cyc;
        tick(1'b0);
        chk1("wr_mem_en", mem_en, 1'b1);
        chk1("wr_mem_wr", mem_wr, 1'b1);
        chk16("wr_mem_addr", mem_addr, 16'h0200);
        chk16("wr_mem_wdata", mem_wdata, 16'h1234);
        repeat (7) tick(1'b0);
        chki("wr_latency", obs_d_done_cyc - t, 6);
        chk16("wr_d_rdata_kept", d_rdata, 16'h0000);

        // reset in the middle of a read's WAIT phase
        a_d_addr = 16'h0300; a_d_wr = 1'b0; d_cnt = 1;
        tick(1'b0); t = cyc;
        repeat (3) tick(1'b0);
        n_d_done = 0;
        tick(1'b1);
        tick(1'b0);
        chk1("rst_busy", busy, 1'b0);
        repeat (10) tick(1'b0);
        chki("rst_no_done", n_d_done, 0);

        // simultaneous requests, twice
        for (int p = 0; p < 2; p++) begin
            a_i_addr = 16'h0020; a_d_addr = 16'h0030; a_d_wr = 1'b0;
            i_cnt = 1; d_cnt = 1; obs_i_done_cyc = -1; obs_d_done_cyc = -1;
            tick(1'b0); t = cyc;
            repeat (15) tick(1'b0);
`ifdef ARB_RR_EN
            chki("pair_d_latency", obs_d_done_cyc - t, (p == 0) ? 6 : 13);
            chki("pair_i_latency", obs_i_done_cyc - t, (p == 0) ? 13 : 6);
`else
            chki("pair_d_latency", obs_d_done_cyc - t, 6);
            chki("pair_i_latency", obs_i_done_cyc - t, 13);
`endif
        end

        // fetch request held across three transactions
        idone_q.delete(); consec_seen = 1'b0;
        a_i_addr = 16'h0040; i_cnt = 3;
        tick(1'b0);
        repeat (25) tick(1'b0);
        chki("burst_count", idone_q.size(), 3);
        for (int k = 1; k < idone_q.size(); k++) chki("burst_gap", idone_q[k] - idone_q[k-1], 7);
        chk1("burst_mem_en_b2b", consec_seen, 1'b0);

        // randomized traffic with occasional resets
        rnd_mode = 1'b1;
        repeat (600) tick($urandom_range(0, 149) == 0);
        rnd_mode = 1'b0;
        repeat (20) tick(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
